uart_alu_intf: RTL

//  Command interface downstream of the UART receiver. Consumes received bytes (rx_done_tick/dout),

---
 rtl/uart_alu_intf.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/uart_alu_intf.sv
// Command interface between the UART receiver, the ALU and the UART transmitter.
// It collects {A, B, opcode} frames and sends each ALU result back.
// Optional inter-byte timeout: define INTF_TIMEOUT_EN.
module uart_alu_intf #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx_done_tick,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic [NB_DATA-1:0] alu_result,
  input  logic               tx_done_tick,
  output logic [NB_DATA-1:0] op_a,
  output logic [NB_DATA-1:0] op_b,
  output logic [NB_OP-1:0]   op_code,
  output logic               tx_start,
  output logic [NB_DATA-1:0] tx_data,
  output logic               busy,
  output logic               err
);

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    SEND    = 3'd4,
    WAIT_TX = 3'd5
  } state_t;

  state_t           state, state_next;
  logic             load_a, load_b, load_op, load_res, err_next, timeout;
  logic [NB_OP-1:0] opcode_rx;

  assign opcode_rx = rx_data[NB_OP-1:0];

  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    case (op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010):
        op_valid = 1'b1;
      default: op_valid = 1'b0;
    endcase
  endfunction

`ifdef INTF_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer;

  // Timer counts idle cycles while a frame is partially received.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      timer <= '0;
    else if (rx_done_tick || state_next == WAIT_A)
      timer <= '0;
    else if (state == WAIT_B || state == WAIT_OP)
      timer <= timer + 1'b1;
  end

  assign timeout = (timer == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    load_res   = 1'b0;
    err_next   = 1'b0;
    case (state)
      WAIT_A: begin
        if (rx_done_tick) begin
          load_a     = 1'b1;
          state_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (rx_done_tick) begin
          load_b     = 1'b1;
          state_next = WAIT_OP;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (rx_done_tick) begin
          if (op_valid(opcode_rx)) begin
            load_op    = 1'b1;
            state_next = EXEC;
          end else begin
            err_next   = 1'b1;
            state_next = WAIT_A;
          end
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = WAIT_A;
        end
      end
      EXEC: begin
        load_res   = 1'b1;
        state_next = SEND;
      end
      SEND: state_next = WAIT_TX;
      WAIT_TX: begin
        // A byte arriving with tx_done starts the next frame immediately.
        if (tx_done_tick) begin
          if (rx_done_tick) begin
            load_a     = 1'b1;
            state_next = WAIT_B;
          end else begin
            state_next = WAIT_A;
          end
        end
      end
      default: state_next = WAIT_A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WAIT_A;
      op_a     <= '0;
      op_b     <= '0;
      op_code  <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_next;
      tx_start <= (state_next == SEND);
      busy     <= (state_next == EXEC) || (state_next == SEND) || (state_next == WAIT_TX);
      err      <= err_next;
      if (load_a)   op_a    <= rx_data;
      if (load_b)   op_b    <= rx_data;
      if (load_op)  op_code <= opcode_rx;
      if (load_res) tx_data <= alu_result;
    end
  end

endmodule
